// File: rtl/rpsc_pkg.sv
// Shared types and helpers for the RPSC interlock controller.
package rpsc_pkg;

    typedef enum logic [1:0] {
        CH_OK,
        CH_PEND,
        CH_TRIP
    } ch_state_t;

    localparam int SYNC_STAGES = 2;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned lowest_set_idx(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rpsc_interlock_ctrl_if.sv
// Card-level signal bundle of the interlock controller; slave side is the controller.
interface rpsc_interlock_ctrl_if #(
    parameter int N_CH = 6
);
    localparam int FF_W = $clog2(N_CH + 1);

    logic [N_CH-1:0] i_Control;
    logic            i_I_AN_5A;
    logic            i_I_AN_6A;
    logic            i_Tune_OK;
    logic            i_External;
    logic            i_Ack;
    logic            o_Not_Alarm;
    logic            o_Emergency;
    logic            o_I_AN_HIGH_n;
    logic            o_Not_TUNE_OK_Delayed;
    logic [N_CH:0]   o_Fault_Latched;
    logic [FF_W-1:0] o_First_Fault;
    logic            o_First_Valid;

    modport master (
        output i_Control, i_I_AN_5A, i_I_AN_6A, i_Tune_OK, i_External, i_Ack,
        input  o_Not_Alarm, o_Emergency, o_I_AN_HIGH_n, o_Not_TUNE_OK_Delayed,
               o_Fault_Latched, o_First_Fault, o_First_Valid
    );

    modport slave (
        input  i_Control, i_I_AN_5A, i_I_AN_6A, i_Tune_OK, i_External, i_Ack,
        output o_Not_Alarm, o_Emergency, o_I_AN_HIGH_n, o_Not_TUNE_OK_Delayed,
               o_Fault_Latched, o_First_Fault, o_First_Valid
    );

endinterface

// File: rtl/rpsc_debounce_latch.sv
// One interlock channel: debounce a registered bad level, latch the trip, release on ack once healthy.
module rpsc_debounce_latch
    import rpsc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic bad,
    input  logic ack,
    output logic tripped,
    output logic trip_now
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CH_OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter holds the number of consecutive bad cycles seen; it never exceeds CNT_MAX-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            CH_OK: begin
                if (bad) begin
                    if (CNT_ONE == CNT_MAX) begin
                        state_d = CH_TRIP;
                    end else begin
                        state_d = CH_PEND;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CH_PEND: begin
                if (!bad) begin
                    state_d = CH_OK;
                end else if (cnt_q + CNT_ONE == CNT_MAX) begin
                    state_d = CH_TRIP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CH_TRIP: begin
                if (ack && !bad) state_d = CH_OK;
            end
            default: state_d = CH_OK;
        endcase
    end

    assign tripped  = (state_q == CH_TRIP);
    assign trip_now = (state_q != CH_TRIP) && (state_d == CH_TRIP);

endmodule

// File: rtl/rpsc_interlock_ctrl.sv
// Clocked RPSC card-6 interlock: input synchronisers, per-channel fault latches,
// first-fault capture, emergency latch and the timed 5A/6A anode threshold select.
module rpsc_interlock_ctrl
    import rpsc_pkg::*;
#(
    parameter int N_CH              = 6,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int TUNE_DELAY_CYCLES = 1000
) (
    input logic                 clk,
    input logic                 reset,
    rpsc_interlock_ctrl_if.slave bus
);

    localparam int                NA       = N_CH + 4;
    localparam logic [NA-1:0]     SYNC_RST = {4'b0000, {N_CH{1'b1}}};
    localparam int                FF_W     = $clog2(N_CH + 1);
    localparam int                TUNE_W   = $clog2(TUNE_DELAY_CYCLES + 1);
    localparam logic [TUNE_W-1:0] TUNE_MAX = TUNE_W'(TUNE_DELAY_CYCLES);

    logic [SYNC_STAGES-1:0][NA-1:0] sync_q, sync_d;
    logic [NA-1:0]                  synced;
    logic [N_CH:0]                  bad_q, bad_d;
    logic [TUNE_W-1:0]              tune_cnt_q, tune_cnt_d;
    logic                           ntd_q, ntd_d;
    logic                           emerg_q, emerg_d;
    logic                           first_valid_q, first_valid_d;
    logic [FF_W-1:0]                first_fault_q, first_fault_d;
    logic [N_CH:0]                  tripped, trip_now;
    logic                           oc;

    // Synchronised bit layout: {external, tune_ok, 6A, 5A, control[N_CH-1:0]}.
    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= {SYNC_STAGES{SYNC_RST}};
            bad_q         <= '0;
            tune_cnt_q    <= '0;
            ntd_q         <= 1'b1;
            emerg_q       <= 1'b0;
            first_valid_q <= 1'b0;
            first_fault_q <= '0;
        end else begin
            sync_q        <= sync_d;
            bad_q         <= bad_d;
            tune_cnt_q    <= tune_cnt_d;
            ntd_q         <= ntd_d;
            emerg_q       <= emerg_d;
            first_valid_q <= first_valid_d;
            first_fault_q <= first_fault_d;
        end
    end

    always_comb begin
        sync_d[0] = {bus.i_External, bus.i_Tune_OK, bus.i_I_AN_6A, bus.i_I_AN_5A, bus.i_Control};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        // Bad levels are registered once; that register doubles as the live I_AN_HIGH flop.
        oc    = ntd_q ? synced[N_CH] : synced[N_CH+1];
        bad_d = {oc, ~synced[N_CH-1:0]};

        tune_cnt_d = tune_cnt_q;
        if (!synced[N_CH+2]) begin
            tune_cnt_d = '0;
        end else if (tune_cnt_q != TUNE_MAX) begin
            tune_cnt_d = tune_cnt_q + TUNE_W'(1);
        end
        ntd_d = (tune_cnt_d != TUNE_MAX);

        emerg_d = synced[N_CH+3] | (emerg_q & ~bus.i_Ack);

        first_valid_d = first_valid_q;
        first_fault_d = first_fault_q;
        if (!first_valid_q) begin
            if (|trip_now) begin
                first_valid_d = 1'b1;
                first_fault_d = FF_W'(lowest_set_idx(32'(trip_now)));
            end
        end else if (tripped == '0) begin
            first_valid_d = 1'b0;
            first_fault_d = '0;
        end
    end

    for (genvar c = 0; c <= N_CH; c++) begin : g_ch
        rpsc_debounce_latch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_latch (
            .clk     (clk),
            .reset   (reset),
            .bad     (bad_q[c]),
            .ack     (bus.i_Ack),
            .tripped (tripped[c]),
            .trip_now(trip_now[c])
        );
    end

    assign bus.o_Fault_Latched       = tripped;
    assign bus.o_First_Fault         = first_fault_q;
    assign bus.o_First_Valid         = first_valid_q;
    assign bus.o_Emergency           = emerg_q;
    assign bus.o_Not_Alarm           = ~(|tripped | emerg_q);
    assign bus.o_I_AN_HIGH_n         = ~bad_q[N_CH];
    assign bus.o_Not_TUNE_OK_Delayed = ntd_q;

endmodule

// File: tb/tb_rpsc_interlock_ctrl.sv
// Directed bench for rpsc_interlock_ctrl with DEBOUNCE_CYCLES=4 and TUNE_DELAY_CYCLES=10.
module tb_rpsc_interlock_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rpsc_interlock_ctrl_if #(.N_CH(6)) bus ();

    rpsc_interlock_ctrl #(
        .N_CH             (6),
        .DEBOUNCE_CYCLES  (4),
        .TUNE_DELAY_CYCLES(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and park 1ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        bus.i_Ack = 1'b1;
        step(1);
        bus.i_Ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_latched"}, 32'(bus.o_Fault_Latched), 32'h0);
        check_val({tag, "_first_valid"}, 32'(bus.o_First_Valid), 32'h0);
        check_val({tag, "_first_fault"}, 32'(bus.o_First_Fault), 32'h0);
        check_val({tag, "_emergency"}, 32'(bus.o_Emergency), 32'h0);
        check_val({tag, "_not_alarm"}, 32'(bus.o_Not_Alarm), 32'h1);
        check_val({tag, "_ntd"}, 32'(bus.o_Not_TUNE_OK_Delayed), 32'h1);
        check_val({tag, "_ian_high_n"}, 32'(bus.o_I_AN_HIGH_n), 32'h1);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.i_Control  = 6'h3F;
        bus.i_I_AN_5A  = 1'b0;
        bus.i_I_AN_6A  = 1'b0;
        bus.i_Tune_OK  = 1'b0;
        bus.i_External = 1'b0;
        bus.i_Ack      = 1'b0;

        #2;
        check_reset_outputs("rst");
        step(2);
        reset = 1'b0;
        step(3);

        // Short glitch: three low samples never reach the 4-cycle debounce.
        bus.i_Control[2] = 1'b0;
        step(3);
        bus.i_Control[2] = 1'b1;
        step(10);
        check_val("short_latched", 32'(bus.o_Fault_Latched), 32'h0);
        check_val("short_not_alarm", 32'(bus.o_Not_Alarm), 32'h1);

        // Sustained low on ch2: latch rises on edge 6 after the first low sample.
        bus.i_Control[2] = 1'b0;
        step(6);
        check_val("ch2_pre_trip", 32'(bus.o_Fault_Latched), 32'h0);
        step(1);
        check_val("ch2_latched", 32'(bus.o_Fault_Latched), 32'h04);
        check_val("ch2_first", 32'(bus.o_First_Fault), 32'd2);
        check_val("ch2_valid", 32'(bus.o_First_Valid), 32'h1);
        check_val("ch2_not_alarm", 32'(bus.o_Not_Alarm), 32'h0);
        bus.i_Control[2] = 1'b1;
        step(5);
        ack_pulse();
        check_val("ch2_ack_latched", 32'(bus.o_Fault_Latched), 32'h0);
        check_val("ch2_ack_valid_held", 32'(bus.o_First_Valid), 32'h1);
        step(1);
        check_val("ch2_valid_cleared", 32'(bus.o_First_Valid), 32'h0);
        check_val("ch2_first_cleared", 32'(bus.o_First_Fault), 32'h0);

        // Simultaneous trip on ch1 and ch4: lowest index wins first-fault.
        bus.i_Control[4] = 1'b0;
        bus.i_Control[1] = 1'b0;
        step(7);
        check_val("sim_latched", 32'(bus.o_Fault_Latched), 32'h12);
        check_val("sim_first", 32'(bus.o_First_Fault), 32'd1);
        bus.i_Control[1] = 1'b1;
        step(5);
        ack_pulse();
        check_val("sim_partial_ack", 32'(bus.o_Fault_Latched), 32'h10);
        check_val("sim_first_held", 32'(bus.o_First_Fault), 32'd1);
        check_val("sim_valid_held", 32'(bus.o_First_Valid), 32'h1);
        bus.i_Control[4] = 1'b1;
        step(5);
        ack_pulse();
        step(1);
        check_val("sim_all_clear", 32'(bus.o_Fault_Latched), 32'h0);
        check_val("sim_valid_clear", 32'(bus.o_First_Valid), 32'h0);

        // Ack sampled on the very edge ch0 trips: the trip wins.
        bus.i_Control[0] = 1'b0;
        step(6);
        bus.i_Ack = 1'b1;
        step(1);
        bus.i_Ack = 1'b0;
        check_val("coll_latched", 32'(bus.o_Fault_Latched), 32'h01);
        check_val("coll_first", 32'(bus.o_First_Fault), 32'd0);
        check_val("coll_valid", 32'(bus.o_First_Valid), 32'h1);
        bus.i_Control[0] = 1'b1;
        step(5);
        ack_pulse();
        check_val("coll_cleared", 32'(bus.o_Fault_Latched), 32'h0);
        check_val("coll_not_alarm", 32'(bus.o_Not_Alarm), 32'h1);
        step(1);
        check_val("coll_valid_clear", 32'(bus.o_First_Valid), 32'h0);

        // One-cycle external pulse latches emergency on the third edge.
        bus.i_External = 1'b1;
        step(1);
        bus.i_External = 1'b0;
        step(1);
        check_val("emerg_before", 32'(bus.o_Emergency), 32'h0);
        step(1);
        check_val("emerg_set", 32'(bus.o_Emergency), 32'h1);
        step(5);
        check_val("emerg_hold", 32'(bus.o_Emergency), 32'h1);
        bus.i_External = 1'b1;
        step(4);
        ack_pulse();
        check_val("emerg_ack_ignored", 32'(bus.o_Emergency), 32'h1);
        check_val("emerg_not_alarm", 32'(bus.o_Not_Alarm), 32'h0);
        bus.i_External = 1'b0;
        step(4);
        ack_pulse();
        check_val("emerg_cleared", 32'(bus.o_Emergency), 32'h0);
        check_val("emerg_not_alarm_back", 32'(bus.o_Not_Alarm), 32'h1);

        // Anode threshold: 5A in force until tune delay expires, then 6A.
        bus.i_I_AN_5A = 1'b1;
        bus.i_I_AN_6A = 1'b0;
        step(3);
        check_val("an5_high_n", 32'(bus.o_I_AN_HIGH_n), 32'h0);
        step(4);
        check_val("an_latched", 32'(bus.o_Fault_Latched), 32'h40);
        check_val("an_first", 32'(bus.o_First_Fault), 32'd6);
        bus.i_Tune_OK = 1'b1;
        step(11);
        check_val("tune_not_yet", 32'(bus.o_Not_TUNE_OK_Delayed), 32'h1);
        step(1);
        check_val("tune_done", 32'(bus.o_Not_TUNE_OK_Delayed), 32'h0);
        check_val("an6_lag", 32'(bus.o_I_AN_HIGH_n), 32'h0);
        step(1);
        check_val("an6_high_n", 32'(bus.o_I_AN_HIGH_n), 32'h1);
        ack_pulse();
        check_val("an_ack_clear", 32'(bus.o_Fault_Latched), 32'h0);
        bus.i_Tune_OK = 1'b0;
        bus.i_I_AN_5A = 1'b0;
        step(2);
        check_val("tune_drop_lag", 32'(bus.o_Not_TUNE_OK_Delayed), 32'h0);
        step(1);
        check_val("tune_drop", 32'(bus.o_Not_TUNE_OK_Delayed), 32'h1);
        check_val("tune_drop_high_n", 32'(bus.o_I_AN_HIGH_n), 32'h1);

        // Async reset mid-PEND and mid-tune-delay, with emergency latched.
        bus.i_Tune_OK = 1'b1;
        step(6);
        bus.i_Control[3] = 1'b0;
        bus.i_External   = 1'b1;
        step(4);
        check_val("pre_rst_emerg", 32'(bus.o_Emergency), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("arst");
        bus.i_External = 1'b0;
        step(2);
        reset = 1'b0;
        step(6);
        check_val("post_rst_no_trip", 32'(bus.o_Fault_Latched), 32'h0);
        step(1);
        check_val("post_rst_trip", 32'(bus.o_Fault_Latched), 32'h08);
        check_val("post_rst_first", 32'(bus.o_First_Fault), 32'd3);
        step(4);
        check_val("post_rst_tune_not_yet", 32'(bus.o_Not_TUNE_OK_Delayed), 32'h1);
        step(1);
        check_val("post_rst_tune_done", 32'(bus.o_Not_TUNE_OK_Delayed), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rpsc_interlock_ctrl.md
Name: rpsc_interlock_ctrl

Overview:
Clocked, parametrised successor to the RPSC card-6 interlock logic. It covers N_CH supply-control OK inputs plus the anode-overcurrent channel. Each input is synchronised and debounced, and each channel has its own fault latch with first-fault capture and operator acknowledge. The 5A/6A anode-threshold select input is generated internally from a timed TUNE_OK delay, and the block drives the card's Not_Alarm, Emergency and I_AN_HIGH outputs.

Parameters:
N_CH, 6, number of supply-control OK inputs (anode, G1, G2, CA, DR_AMP, RF_PERMIT_TED)
DEBOUNCE_CYCLES, 16, consecutive synchronised-bad cycles before a channel trips (>=1)
TUNE_DELAY_CYCLES, 1000, consecutive synchronised TUNE_OK-high cycles before the 6A threshold applies (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_Control  in  N_CH  per-channel control OK, asynchronous, 1 = healthy
i_I_AN_5A  in  1  anode current above 5A comparator, asynchronous
i_I_AN_6A  in  1  anode current above 6A comparator, asynchronous
i_Tune_OK  in  1  tuning-complete input, asynchronous
i_External  in  1  external emergency request, asynchronous, 1 = emergency
i_Ack  in  1  operator acknowledge, single-cycle pulse, clk domain
o_Not_Alarm  out  1  1 = no latched fault and no emergency
o_Emergency  out  1  latched emergency
o_I_AN_HIGH_n  out  1  live anode overcurrent, active-low, unlatched
o_Not_TUNE_OK_Delayed  out  1  1 = 5A threshold in force
o_Fault_Latched  out  N_CH+1  per-channel latch; bit N_CH = anode overcurrent
o_First_Fault  out  $clog2(N_CH+1)  index of the first channel to trip
o_First_Valid  out  1  o_First_Fault holds a valid index

Behaviour:
- Sync: every asynchronous input passes a 2-flop synchroniser; "synced" below means the synchroniser output.
- Reset values:
  - o_Fault_Latched = 0, o_First_Valid = 0, o_First_Fault = 0.
  - o_Emergency = 0, o_Not_Alarm = 1.
  - o_Not_TUNE_OK_Delayed = 1 (conservative 5A threshold), o_I_AN_HIGH_n = 1.
  - All counters 0; synchronisers clear to the healthy level (control = 1, others = 0).
  - Reset asserted mid-debounce or mid-tune-delay discards all progress.
- Anode overcurrent: oc = o_Not_TUNE_OK_Delayed ? synced 5A : synced 6A. o_I_AN_HIGH_n = ~oc, registered, one cycle after the synced value. oc is the "bad" level for channel N_CH; for channels 0..N_CH-1 the bad level is synced i_Control[c] = 0.
- Per-channel FSM (states OK, PEND, TRIP):
  - OK -> PEND when the channel is bad; the counter loads 1.
  - PEND: while bad, the counter increments. On the cycle the counter reaches DEBOUNCE_CYCLES -> TRIP. Any good cycle -> OK, counter cleared.
  - DEBOUNCE_CYCLES = 1 goes OK -> TRIP directly.
  - Trip latency: o_Fault_Latched[c] rises 2 + DEBOUNCE_CYCLES cycles after the first edge that samples the raw input bad.
  - TRIP -> OK only on a cycle with i_Ack = 1 while the channel is good. An ack while the channel is still bad is ignored for that channel.
  - o_Fault_Latched[c] = (state == TRIP).
- First fault:
  - When o_First_Valid = 0 and any channel enters TRIP, capture the lowest index among the channels entering TRIP that cycle and set o_First_Valid.
  - Hold the capture until o_Fault_Latched is all zero, then clear o_First_Valid and o_First_Fault on the next cycle.
- Emergency: synced i_External = 1 sets o_Emergency on the next edge, with no debounce. It clears only on i_Ack with synced i_External = 0.
- Simultaneous events: a trip (or emergency set) and i_Ack in the same cycle -> the trip/set wins and the latch stays 1.
- o_Not_Alarm = ~(|o_Fault_Latched | o_Emergency), combinational from registers.
- Tune delay:
  - Saturating counter increments while synced i_Tune_OK = 1.
  - o_Not_TUNE_OK_Delayed falls on the edge where the counter reaches TUNE_DELAY_CYCLES.
  - Synced i_Tune_OK = 0 clears the counter and sets o_Not_TUNE_OK_Delayed = 1 on the next edge.
- Counter widths: $clog2(DEBOUNCE_CYCLES+1) and $clog2(TUNE_DELAY_CYCLES+1). Neither counter wraps.

Decomposition:
- Package rpsc_pkg: enum ch_state_t {CH_OK, CH_PEND, CH_TRIP}, the synchroniser stage count constant (2), and the channel-index function for the lowest set bit.
- Sub-module rpsc_debounce_latch (parameter DEBOUNCE_CYCLES; ports clk, reset, bad, ack, tripped, trip_now). It is instantiated N_CH+1 times via generate.

Test Plan:
- Debounce with DEBOUNCE_CYCLES=4: i_Control[2] low for 3 cycles, then high -> no latch, o_Not_Alarm stays 1. Low for 6 cycles -> o_Fault_Latched[2] = 1 at cycle 6 after the first low sample, o_First_Fault = 2, o_Not_Alarm = 0.
- Simultaneous trip: i_Control[4] and i_Control[1] fall on the same edge -> both latches set on the same cycle, o_First_Fault = 1. Ack with ch1 healthy and ch4 still low -> only bit 1 clears, o_First_Fault stays 1.
- Ack/trip collision: i_Ack is pulsed on the exact cycle ch0 trips -> o_Fault_Latched[0] stays 1. A second ack after recovery -> all clear, and o_First_Valid = 0 one cycle later.
- Threshold select with TUNE_DELAY_CYCLES=10, i_I_AN_5A = 1, i_I_AN_6A = 0: o_I_AN_HIGH_n = 0 and the anode channel trips. Raise i_Tune_OK -> after 10 synced cycles o_Not_TUNE_OK_Delayed = 0 and o_I_AN_HIGH_n = 1. Drop i_Tune_OK -> o_Not_TUNE_OK_Delayed = 1 the next cycle.
- Emergency: i_External pulsed for 1 cycle -> o_Emergency = 1 three edges later and held. Ack while i_External = 1 -> held. Ack after it falls -> cleared, o_Not_Alarm = 1.
- Async reset asserted mid-PEND and mid-tune-delay -> all outputs return to their reset values immediately (no clock edge needed), and the counters restart from 0 after release.
